// File: rtl/stratixii_lvds_pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stratixii_lvds_pll_ctrl_pkg
// Brief    : Shared types and helpers for the LVDS fast-PLL lock supervisor.
// Revision : 1.0  initial release
// ============================================================================
package stratixii_lvds_pll_ctrl_pkg;

    // Supervisor states; the encoding is fixed at 3 bits
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one bit
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stratixii_lvds_pll_ctrl_pll_lock_sync.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sync
// Brief    : Two-flop synchronizer bringing the raw PLL lock flag into the
//            controller clock domain; both flops clear on reset.
// Revision : 1.0  initial release
// ============================================================================
module pll_lock_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous lock flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/stratixii_lvds_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stratixii_lvds_pll_ctrl
// Brief    : Bring-up and lock supervisor for the Stratix II fast LVDS PLL.
//            Sequences PLL areset/ena, waits for a stable lock, releases the
//            SERDES datapath, retries on lock timeout and reports a fault.
//            Build option PLL_CTRL_AUTO_RELOCK_EN: loss of lock in RUN
//            restarts bring-up instead of entering FAULT.
// Revision : 1.0  initial release
// ============================================================================
module stratixii_lvds_pll_ctrl
    import stratixii_lvds_pll_ctrl_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               pll_locked,
    output logic                               pll_areset,
    output logic                               pll_ena,
    output logic                               rx_enable,
    output logic                               ready,
    output logic                               fault,
    output logic                               lock_lost,
    output logic [clog2(MAX_RETRIES+1)-1:0]    retry_count
);

    localparam int c_RW = clog2(MAX_RETRIES + 1);
    localparam int c_HW = clog2(RESET_HOLD_CYCLES + 1);
    localparam int c_SW = clog2(LOCK_STABLE_CYCLES + 1);
    localparam int c_TW = clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [c_SW-1:0] c_STB_LAST  = c_SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_RW-1:0] c_RETRY_MAX = c_RW'(MAX_RETRIES);

    state_t            r_state;
    logic [c_HW-1:0]   r_hold_cnt;
    logic [c_SW-1:0]   r_stb_cnt;
    logic [c_TW-1:0]   r_tmo_cnt;
    logic [c_RW-1:0]   r_retry;
    logic              r_lock_lost;
    logic              w_locked_s;

    pll_lock_sync u_lock_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (pll_locked),
        .sync_out (w_locked_s)
    );

    // Supervisor FSM together with its hold, stable and timeout counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_stb_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_retry     <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_lock_lost <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= RESET;
                        r_hold_cnt <= '0;
                        r_retry    <= '0;
                    end
                end
                RESET: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state   <= WAIT_LOCK;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                WAIT_LOCK, STABLE: begin
                    // Timeout spans both states and wins over lock events
                    if (r_tmo_cnt != c_TMO_LAST) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                    if (r_tmo_cnt == c_TMO_LAST) begin
                        r_hold_cnt <= '0;
                        if (r_retry < c_RETRY_MAX) begin
                            r_state <= RESET;
                            r_retry <= r_retry + 1'b1;
                        end else begin
                            r_state <= FAULT;
                        end
                    end else if (r_state == WAIT_LOCK) begin
                        if (w_locked_s) begin
                            r_state   <= STABLE;
                            r_stb_cnt <= '0;
                        end
                    end else if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                    end else if (r_stb_cnt == c_STB_LAST) begin
                        r_state <= RUN;
                    end else begin
                        r_stb_cnt <= r_stb_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!w_locked_s) begin
                        r_lock_lost <= 1'b1;
`ifdef PLL_CTRL_AUTO_RELOCK_EN
                        r_state     <= RESET;
                        r_hold_cnt  <= '0;
                        r_retry     <= '0;
`else
                        r_state     <= FAULT;
`endif
                    end
                end
                FAULT: begin
                    if (start) begin
                        r_state    <= RESET;
                        r_hold_cnt <= '0;
                        r_retry    <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode of the state register onto the PLL and datapath controls
    always_comb begin
        pll_areset = 1'b1;
        pll_ena    = 1'b0;
        rx_enable  = 1'b0;
        ready      = 1'b0;
        fault      = 1'b0;
        case (r_state)
            RESET:     begin pll_areset = 1'b1; pll_ena = 1'b1; end
            WAIT_LOCK: begin pll_areset = 1'b0; pll_ena = 1'b1; end
            STABLE:    begin pll_areset = 1'b0; pll_ena = 1'b1; end
            RUN:       begin pll_areset = 1'b0; pll_ena = 1'b1; rx_enable = 1'b1; ready = 1'b1; end
            FAULT:     begin fault = 1'b1; end
            default:   begin pll_areset = 1'b1; end
        endcase
    end

    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_stratixii_lvds_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stratixii_lvds_pll_ctrl
// Brief    : Self-checking bench for the LVDS PLL lock supervisor with a
//            phase/timer reference model and directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_stratixii_lvds_pll_ctrl;

    localparam int HOLD  = 4;
    localparam int STB   = 8;
    localparam int TMO   = 32;
    localparam int MAXR  = 2;

    logic       clock = 1'b0;
    logic       reset, start, pll_locked;
    logic       pll_areset, pll_ena, rx_enable, ready, fault, lock_lost;
    logic [1:0] retry_count;

    int n_total = 0;
    int n_pass  = 0;

    stratixii_lvds_pll_ctrl #(
        .RESET_HOLD_CYCLES   (HOLD),
        .LOCK_STABLE_CYCLES  (STB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pll_locked  (pll_locked),
        .pll_areset  (pll_areset),
        .pll_ena     (pll_ena),
        .rx_enable   (rx_enable),
        .ready       (ready),
        .fault       (fault),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase + time spent in it; lock seen two edges late
    localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2, P_STB = 3, P_RUN = 4, P_FLT = 5;
    int m_phase = P_IDLE;
    int m_in_phase = 0;    // edges already spent in the current phase
    int m_attempt = 0;     // edges since the lock wait began
    int m_retries = 0;
    bit m_lost = 0;
    bit m_seen1 = 0, m_seen2 = 0;   // pll_locked sampled one / two edges ago

    always @(posedge clock) begin
        int nxt;
        bit lk;
        lk = m_seen2;
        nxt = m_phase;
        m_lost = 0;
        if (reset) begin
            m_phase = P_IDLE; m_in_phase = 0; m_attempt = 0; m_retries = 0;
            m_seen1 = 0; m_seen2 = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin nxt = P_RST; m_retries = 0; end
                P_RST:  if (m_in_phase + 1 == HOLD) begin nxt = P_WAIT; m_attempt = 0; end
                P_WAIT, P_STB: begin
                    m_attempt++;
                    if (m_attempt == TMO) begin
                        if (m_retries < MAXR) begin nxt = P_RST; m_retries++; end
                        else nxt = P_FLT;
                    end else if (m_phase == P_WAIT) begin
                        if (lk) nxt = P_STB;
                    end else if (!lk) nxt = P_WAIT;
                    else if (m_in_phase + 1 == STB) nxt = P_RUN;
                end
                P_RUN: if (!lk) begin
                    m_lost = 1;
`ifdef PLL_CTRL_AUTO_RELOCK_EN
                    nxt = P_RST; m_retries = 0;
`else
                    nxt = P_FLT;
`endif
                end
                P_FLT: if (start) begin nxt = P_RST; m_retries = 0; end
                default: nxt = P_IDLE;
            endcase
            if (nxt != m_phase) m_in_phase = 0;
            else m_in_phase++;
            m_phase = nxt;
            m_seen2 = m_seen1;
            m_seen1 = pll_locked;
        end
    end

    // Continuous comparison of every output against the model
    always @(negedge clock) begin
        chk("m_pll_areset", pll_areset, int'(m_phase == P_IDLE || m_phase == P_RST || m_phase == P_FLT));
        chk("m_pll_ena", pll_ena, int'(m_phase >= P_RST && m_phase <= P_RUN));
        chk("m_rx_enable", rx_enable, int'(m_phase == P_RUN));
        chk("m_ready", ready, int'(m_phase == P_RUN));
        chk("m_fault", fault, int'(m_phase == P_FLT));
        chk("m_lock_lost", lock_lost, int'(m_lost));
        chk("m_retry_count", retry_count, m_retries);
    end

    task automatic count_reset(output int n);
        n = 0;
        while (pll_areset && pll_ena && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        int n, phases, maxr;
        bit prev, cur;
        reset = 1'b1; start = 1'b0; pll_locked = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_areset", pll_areset, 1);
        chk("rst_ena", pll_ena, 0);
        chk("rst_ready", ready, 0);
        chk("rst_retry", retry_count, 0);
        reset = 1'b0;

        // Normal bring-up
        start = 1'b1; @(negedge clock); start = 1'b0;
        count_reset(n);
        chk("bringup_reset_len", n, HOLD);
        pll_locked = 1'b1;
        wait_ready(n);
        chk("bringup_ready_edges", n, 11);   // first edge sees lock, ready 10 edges later
        chk("bringup_rx_enable", rx_enable, 1);

        // start held high in RUN has no effect
        start = 1'b1; repeat (5) @(negedge clock); start = 1'b0;
        chk("run_start_ready", ready, 1);

        // Loss of lock in RUN
        pll_locked = 1'b0;
        n = 0;
        while (ready && n < 20) begin @(negedge clock); n++; end
        chk("loss_ready_edges", n, 3);
        chk("loss_pulse", lock_lost, 1);
`ifdef PLL_CTRL_AUTO_RELOCK_EN
        count_reset(n);
        chk("relock_reset_len", n, HOLD);
        chk("relock_pulse_end", lock_lost, 0);
        pll_locked = 1'b1;
        wait_ready(n);
        chk("relock_ready_edges", n, 11);
`else
        @(negedge clock);
        chk("loss_pulse_end", lock_lost, 0);
        chk("loss_fault", fault, 1);
        pll_locked = 1'b1;
        start = 1'b1; @(negedge clock); start = 1'b0;
        chk("recover_retry", retry_count, 0);
        wait_ready(n);
        chk("recover_ready", ready, 1);
`endif

        // Reset in RUN, start ignored while reset is high
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        chk("runrst_ena", pll_ena, 0);
        chk("runrst_ready", ready, 0);
        @(negedge clock);
        chk("runrst_hold_ena", pll_ena, 0);
        reset = 1'b0; start = 1'b0; pll_locked = 1'b0;
        @(negedge clock);

        // Reset in WAIT_LOCK
        start = 1'b1; @(negedge clock); start = 1'b0;
        count_reset(n);
        chk("wait_entry_areset", pll_areset, 0);
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        chk("waitrst_areset", pll_areset, 1);
        chk("waitrst_ena", pll_ena, 0);
        reset = 1'b0;

        // Lock glitch in STABLE with start held high throughout
        @(negedge clock);
        count_reset(n);
        pll_locked = 1'b1;
        repeat (8) @(negedge clock);
        pll_locked = 1'b0; @(negedge clock);
        pll_locked = 1'b1;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clock);
            n++;
            if (n == 2) chk("glitch_ready_low", ready, 0);
        end
        chk("glitch_restart_edges", n, 11);
        start = 1'b0;

        // Lock timeout: three attempts, then FAULT
        reset = 1'b1; pll_locked = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        start = 1'b1;
        n = 0; phases = 0; maxr = 0; prev = 1'b0;
        while (!fault && n < 400) begin
            @(negedge clock);
            n++;
            if (n == 1) start = 1'b0;
            cur = pll_areset && pll_ena;
            if (cur && !prev) phases++;
            prev = cur;
            if (int'(retry_count) > maxr) maxr = int'(retry_count);
        end
        chk("tmo_edges", n, 109);
        chk("tmo_phases", phases, 3);
        chk("tmo_max_retry", maxr, 2);
        chk("tmo_fault_areset", pll_areset, 1);
        chk("tmo_fault_ena", pll_ena, 0);
        start = 1'b1; @(negedge clock); start = 1'b0;
        chk("tmo_restart_retry", retry_count, 0);
        chk("tmo_restart_ena", pll_ena, 1);
        chk("tmo_restart_fault", fault, 0);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
